memory_access_stage: RTL and testbench

Load/store stage between `execute` and the register write-back. It takes one memory operation at a time from `execute`, runs it against the single-port `memory` block, and returns load results to the register file. Sub-word stores are done as read-modify-write because `memory` only writes full words. `busy` stalls `fetch`/`execute` while an operation is in flight.

---
 rtl/memory_access_stage.sv | 182 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// Load/store stage: runs one memory operation at a time against a single-port word memory.
// Sub-word stores are handled as read-modify-write because the memory only writes full words.
module memory_access_stage #(
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     operation_valid,
  input  logic                     operation_load,
  input  logic [2:0]               operation_funct3,
  input  logic [ADDRESS_WIDTH-1:0] operation_address,
  input  logic [31:0]              operation_store_data,
  input  logic [4:0]               operation_rd,
  output logic                     busy,
  output logic                     read_enable,
  output logic [31:0]              read_address,
  input  logic [31:0]              read_value,
  output logic                     write_enable,
  output logic [31:0]              write_address,
  output logic [31:0]              write_value,
  output logic                     write_back_enable,
  output logic [4:0]               write_back_register,
  output logic [31:0]              write_back_value,
  output logic                     misaligned,
  output logic                     illegal
);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, RMW_REQ, RMW_WAIT, STORE_WRITE
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] word_address_reg;
  logic [1:0]  offset_reg;
  logic [15:0] store_half_reg;
  logic [2:0]  funct3_reg;
  logic [4:0]  rd_reg;

  logic [31:0] op_word_address;
  logic        op_illegal, op_misaligned;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_result, merged_word;

  logic        read_enable_next, write_enable_next, write_back_enable_next;
  logic        misaligned_next, illegal_next;
  logic [31:0] read_address_next, write_address_next, write_value_next, write_back_value_next;
  logic [4:0]  write_back_register_next;

  assign busy            = (state_reg != IDLE);
  assign op_word_address = 32'(operation_address) & ~32'd3;

  // Legality depends on direction: BU/HU exist only as loads.
  always_comb begin
    op_illegal = 1'b0;
    if (operation_load)
      op_illegal = (operation_funct3 == 3'b011) || (operation_funct3[2:1] == 2'b11);
    else
      op_illegal = (operation_funct3[2] == 1'b1) || (operation_funct3[1:0] == 2'b11);
  end

  assign op_misaligned = ((operation_funct3[1:0] == 2'b01) && operation_address[0]) ||
                         ((operation_funct3[1:0] == 2'b10) && (operation_address[1:0] != 2'b00));

  assign load_byte = read_value[{offset_reg, 3'b000} +: 8];
  assign load_half = read_value[{offset_reg[1], 4'b0000} +: 16];

  always_comb begin
    load_result = read_value;
    case (funct3_reg)
      3'b000:  load_result = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_result = {24'd0, load_byte};
      3'b001:  load_result = {{16{load_half[15]}}, load_half};
      3'b101:  load_result = {16'd0, load_half};
      default: load_result = read_value;
    endcase
  end

  // Byte lanes of the RMW word: replace the addressed lane(s), keep the rest.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic       lane_hit;
    logic [7:0] store_lane;
    assign lane_hit   = funct3_reg[0] ? (offset_reg[1] == 1'(gi / 2)) : (offset_reg == 2'(gi));
    assign store_lane = funct3_reg[0] ? store_half_reg[8*(gi%2) +: 8] : store_half_reg[7:0];
    assign merged_word[8*gi +: 8] = lane_hit ? store_lane : read_value[8*gi +: 8];
  end

  always_comb begin
    state_next               = state_reg;
    read_enable_next         = 1'b0;
    write_enable_next        = 1'b0;
    write_back_enable_next   = 1'b0;
    misaligned_next          = 1'b0;
    illegal_next             = 1'b0;
    read_address_next        = read_address;
    write_address_next       = write_address;
    write_value_next         = write_value;
    write_back_register_next = write_back_register;
    write_back_value_next    = write_back_value;
    unique case (state_reg)
      IDLE: begin
        if (operation_valid) begin
          if (op_illegal) begin
            illegal_next = 1'b1;
          end else if (op_misaligned) begin
            misaligned_next = 1'b1;
          end else if (operation_load) begin
            state_next        = LOAD_REQ;
            read_enable_next  = 1'b1;
            read_address_next = op_word_address;
          end else if (operation_funct3 == 3'b010) begin
            state_next         = STORE_WRITE;
            write_enable_next  = 1'b1;
            write_address_next = op_word_address;
            write_value_next   = operation_store_data;
          end else begin
            state_next        = RMW_REQ;
            read_enable_next  = 1'b1;
            read_address_next = op_word_address;
          end
        end
      end
      LOAD_REQ:  state_next = LOAD_WAIT;
      LOAD_WAIT: begin
        state_next               = IDLE;
        write_back_enable_next   = (rd_reg != 5'd0);
        write_back_register_next = rd_reg;
        write_back_value_next    = load_result;
      end
      RMW_REQ:   state_next = RMW_WAIT;
      RMW_WAIT: begin
        state_next         = STORE_WRITE;
        write_enable_next  = 1'b1;
        write_address_next = word_address_reg;
        write_value_next   = merged_word;
      end
      STORE_WRITE: state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg           <= IDLE;
      word_address_reg    <= 32'd0;
      offset_reg          <= 2'd0;
      store_half_reg      <= 16'd0;
      funct3_reg          <= 3'd0;
      rd_reg              <= 5'd0;
      read_enable         <= 1'b0;
      read_address        <= 32'd0;
      write_enable        <= 1'b0;
      write_address       <= 32'd0;
      write_value         <= 32'd0;
      write_back_enable   <= 1'b0;
      write_back_register <= 5'd0;
      write_back_value    <= 32'd0;
      misaligned          <= 1'b0;
      illegal             <= 1'b0;
    end else begin
      state_reg           <= state_next;
      if (state_reg == IDLE && operation_valid) begin
        word_address_reg <= op_word_address;
        offset_reg       <= operation_address[1:0];
        store_half_reg   <= operation_store_data[15:0];
        funct3_reg       <= operation_funct3;
        rd_reg           <= operation_rd;
      end
      read_enable         <= read_enable_next;
      read_address        <= read_address_next;
      write_enable        <= write_enable_next;
      write_address       <= write_address_next;
      write_value         <= write_value_next;
      write_back_enable   <= write_back_enable_next;
      write_back_register <= write_back_register_next;
      write_back_value    <= write_back_value_next;
      misaligned          <= misaligned_next;
      illegal             <= illegal_next;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench for memory_access_stage: the driver pushes expected memory/write-back events
// from a word-level reference model; a negedge monitor pops and compares every DUT output event.
module tb_memory_access_stage;

  localparam int K_RD = 0, K_WR = 1, K_WB = 2, K_MIS = 3, K_ILL = 4;

  typedef struct {
    int          kind;
    int unsigned cyc;
    bit [31:0]   addr;
    bit [31:0]   val;
    bit [4:0]    rd;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        operation_valid, operation_load;
  logic [2:0]  operation_funct3;
  logic [31:0] operation_address, operation_store_data;
  logic [4:0]  operation_rd;
  logic        busy, read_enable, write_enable, write_back_enable, misaligned, illegal;
  logic [31:0] read_address, read_value, write_address, write_value, write_back_value;
  logic [4:0]  write_back_register;

  logic        pre_valid = 1'b0;
  logic [31:0] pre_addr = 32'd0, pre_data = 32'd0;
  logic [31:0] fix_mem [0:63];

  bit [31:0]   ref_mem [bit [31:0]];
  ev_t         exp_q[$];
  int          busy_q[$];
  int unsigned cyc = 0;
  int          compared = 0, mismatched = 0, run = 0;

  memory_access_stage #(.ADDRESS_WIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .operation_valid(operation_valid), .operation_load(operation_load),
    .operation_funct3(operation_funct3), .operation_address(operation_address),
    .operation_store_data(operation_store_data), .operation_rd(operation_rd),
    .busy(busy), .read_enable(read_enable), .read_address(read_address),
    .read_value(read_value), .write_enable(write_enable), .write_address(write_address),
    .write_value(write_value), .write_back_enable(write_back_enable),
    .write_back_register(write_back_register), .write_back_value(write_back_value),
    .misaligned(misaligned), .illegal(illegal)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Synchronous single-port memory the stage talks to; also preloadable from the bench.
  always @(posedge clock) begin
    if (read_enable) read_value <= fix_mem[read_address[7:2]];
    if (write_enable) fix_mem[write_address[7:2]] <= write_value;
    if (pre_valid) fix_mem[pre_addr[7:2]] <= pre_data;
  end

  function automatic string kname(input int k);
    case (k)
      K_RD:    return "read";
      K_WR:    return "write";
      K_WB:    return "writeback";
      K_MIS:   return "misaligned";
      default: return "illegal";
    endcase
  endfunction

  task automatic chk(input string name, input bit [31:0] act, input bit [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_ev(input int kind, input bit [31:0] addr, input bit [31:0] val, input bit [4:0] rd);
    ev_t e;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL event: got %s cyc=%0d addr=%h val=%h rd=%0d, expected no event",
               kname(kind), cyc, addr, val, rd);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.addr != addr || e.val != val || e.rd != rd) begin
        mismatched++;
        $display("FAIL event: got %s cyc=%0d addr=%h val=%h rd=%0d, expected %s cyc=%0d addr=%h val=%h rd=%0d",
                 kname(kind), cyc, addr, val, rd, kname(e.kind), e.cyc, e.addr, e.val, e.rd);
      end else begin
        $display("ok %s cyc=%0d addr=%h val=%h rd=%0d", kname(kind), cyc, addr, val, rd);
      end
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      run = 0;
    end else begin
      if (read_enable && write_enable) begin
        compared++; mismatched++;
        $display("FAIL port_conflict: got read_enable=1 write_enable=1, expected at most one");
      end
      if (read_enable)       check_ev(K_RD, read_address, 32'd0, 5'd0);
      if (write_enable)      check_ev(K_WR, write_address, write_value, 5'd0);
      if (write_back_enable) check_ev(K_WB, 32'd0, write_back_value, write_back_register);
      if (misaligned)        check_ev(K_MIS, 32'd0, 32'd0, 5'd0);
      if (illegal)           check_ev(K_ILL, 32'd0, 32'd0, 5'd0);
      if (busy) begin
        run++;
      end else if (run > 0) begin
        compared++;
        if (busy_q.size() == 0) begin
          mismatched++;
          $display("FAIL busy_cycles: got %0d, expected no busy period", run);
        end else begin
          int exp_run;
          exp_run = busy_q.pop_front();
          if (exp_run != run) begin
            mismatched++;
            $display("FAIL busy_cycles: got %0d, expected %0d", run, exp_run);
          end
        end
        run = 0;
      end
    end
  end

  function automatic void push_ev(input int kind, input int unsigned c, input bit [31:0] addr,
                                  input bit [31:0] val, input bit [4:0] rd);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = addr; e.val = val; e.rd = rd;
    exp_q.push_back(e);
  endfunction

  // Reference model: what an accepted request must produce, at which cycle after acceptance a.
  function automatic void model(input bit ld, input bit [2:0] f3, input bit [31:0] addr,
                                input bit [31:0] sd, input bit [4:0] rd, input int unsigned a);
    bit [31:0] word, w, v;
    int unsigned off, sh;
    bit ill, mis;
    word = addr & ~32'd3;
    off  = addr % 4;
    if (ld) ill = (f3 == 3) || (f3 == 6) || (f3 == 7);
    else    ill = (f3 > 2);
    mis = ((f3 == 1 || f3 == 5) && (addr % 2 != 0)) || (f3 == 2 && off != 0);
    if (ill) begin
      push_ev(K_ILL, a, 0, 0, 0);
    end else if (mis) begin
      push_ev(K_MIS, a, 0, 0, 0);
    end else if (ld) begin
      w = ref_mem[word];
      push_ev(K_RD, a, word, 0, 0);
      if (f3 == 0 || f3 == 4) begin
        v = (w >> (8 * off)) & 32'hFF;
        if (f3 == 0 && v >= 128) v = v - 256;
      end else if (f3 == 1 || f3 == 5) begin
        v = (w >> (16 * (off / 2))) & 32'hFFFF;
        if (f3 == 1 && v >= 32768) v = v - 65536;
      end else begin
        v = w;
      end
      if (rd != 0) push_ev(K_WB, a + 2, 0, v, rd);
      busy_q.push_back(2);
    end else if (f3 == 2) begin
      push_ev(K_WR, a, word, sd, 0);
      ref_mem[word] = sd;
      busy_q.push_back(1);
    end else begin
      w  = ref_mem[word];
      sh = (f3 == 0) ? 8 * off : 16 * (off / 2);
      if (f3 == 0) w = (w & ~(32'hFF << sh)) | ((sd & 32'hFF) << sh);
      else         w = (w & ~(32'hFFFF << sh)) | ((sd & 32'hFFFF) << sh);
      push_ev(K_RD, a, word, 0, 0);
      push_ev(K_WR, a + 2, word, w, 0);
      ref_mem[word] = w;
      busy_q.push_back(3);
    end
  endfunction

  // Called at a negedge; presents the request and holds it until accepted. Returns at the
  // negedge after acceptance with operation_valid still high.
  task automatic issue(input bit ld, input bit [2:0] f3, input bit [31:0] addr,
                       input bit [31:0] sd, input bit [4:0] rd);
    int unsigned k;
    bit b, ok;
    operation_valid = 1'b1; operation_load = ld; operation_funct3 = f3;
    operation_address = addr; operation_store_data = sd; operation_rd = rd;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      k = cyc; b = busy;
      @(posedge clock);
      if (!b) begin
        ok = 1'b1;
        model(ld, f3, addr, sd, rd, k + 1);
      end
      @(negedge clock);
    end
    if (!ok) begin
      compared++; mismatched++;
      $display("FAIL accept: got busy for 20 cycles, expected acceptance of addr=%h", addr);
    end
  endtask

  task automatic idle(input int n);
    operation_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic set_word(input bit [31:0] addr, input bit [31:0] data);
    pre_valid = 1'b1; pre_addr = addr; pre_data = data;
    ref_mem[addr] = data;
    @(negedge clock);
    pre_valid = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_read_enable"}, 32'(read_enable), 0);
    chk({tag, "_read_address"}, read_address, 0);
    chk({tag, "_write_enable"}, 32'(write_enable), 0);
    chk({tag, "_write_address"}, write_address, 0);
    chk({tag, "_write_value"}, write_value, 0);
    chk({tag, "_write_back_enable"}, 32'(write_back_enable), 0);
    chk({tag, "_write_back_register"}, 32'(write_back_register), 0);
    chk({tag, "_write_back_value"}, write_back_value, 0);
    chk({tag, "_misaligned"}, 32'(misaligned), 0);
    chk({tag, "_illegal"}, 32'(illegal), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [31:0] old, addr;
    bit [2:0]  f3;
    bit        ld;
    operation_valid = 1'b0; operation_load = 1'b0; operation_funct3 = 3'd0;
    operation_address = 32'd0; operation_store_data = 32'd0; operation_rd = 5'd0;
    #1 check_quiet("reset");
    @(posedge clock); #2 reset = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 64; i++) set_word(32'h100 + 4 * i, $urandom);

    // Directed cases
    set_word(32'h100, 32'hDEADBEEF);
    issue(1, 3'b010, 32'h100, 0, 5'd5); idle(3);
    set_word(32'h100, 32'h80FF7F01);
    issue(1, 3'b000, 32'h103, 0, 5'd1);
    issue(1, 3'b100, 32'h103, 0, 5'd2);
    issue(1, 3'b001, 32'h102, 0, 5'd3); idle(3);
    set_word(32'h100, 32'h11223344);
    issue(0, 3'b000, 32'h101, 32'h000000AB, 5'd0); idle(4);
    issue(1, 3'b010, 32'h100, 0, 5'd4);
    issue(1, 3'b010, 32'h102, 0, 5'd6);
    issue(1, 3'b011, 32'h100, 0, 5'd7);
    issue(0, 3'b100, 32'h100, 32'h1, 5'd0); idle(3);

    // Reset while an SH sits in RMW_WAIT: the write must never appear
    old = ref_mem[32'h104];
    issue(0, 3'b001, 32'h106, 32'h0000BEEF, 5'd0);
    operation_valid = 1'b0;
    @(posedge clock); #2 reset = 1'b1;
    #1 check_quiet("abort");
    exp_q.delete(); busy_q.delete(); ref_mem[32'h104] = old;
    @(posedge clock); #2 reset = 1'b0;
    @(negedge clock);
    issue(1, 3'b010, 32'h104, 0, 5'd9); idle(3);

    // rd=0 load, then back-to-back requests held across busy
    issue(1, 3'b010, 32'h108, 0, 5'd0);
    issue(0, 3'b010, 32'h10C, 32'h12345678, 5'd0);
    issue(1, 3'b010, 32'h10C, 0, 5'd10);
    issue(0, 3'b001, 32'h10E, 32'hCAFEF00D, 5'd0);
    issue(1, 3'b101, 32'h10E, 0, 5'd11);
    idle(3);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      ld   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      addr = 32'h100 + $urandom_range(0, 255);
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'b10) addr = addr & ~32'd3;
        else if (f3[1:0] == 2'b01) addr = addr & ~32'd1;
      end
      issue(ld, f3, addr, $urandom, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(1);
    for (int t = 0; t < 50 && exp_q.size() > 0; t++) @(negedge clock);
    idle(4);
    chk("pending_events", exp_q.size(), 0);
    chk("pending_busy_periods", busy_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
